// File: rtl/bus_datapath_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bus_datapath_pkg
// Purpose  : Shared definitions for the SimpleCPU datapath, controller and
//            decoder: default widths, SP reset value, register-select codes
//            and a small helper for bus-contention detection.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package bus_datapath_pkg;

  localparam int              DP_WIDTH    = 16;
  localparam int              DP_PC_W     = 8;
  localparam int              DP_OPND_W   = 8;
  localparam logic [15:0]     DP_SP_RESET = 16'h00FF;
  localparam int              DP_N_SRC    = 8;

  // Register-select codes carried in instruction operands. Code 0 means the
  // operand refers to memory through MAR rather than a data register.
  typedef enum logic [2:0] {
    SEL_MAR = 3'd0,
    SEL_DR0 = 3'd1,
    SEL_BP  = 3'd2,
    SEL_SP  = 3'd3,
    SEL_DR1 = 3'd4
  } reg_sel_e;

  // True when two or more bits of v are set: clearing the lowest set bit
  // leaves something behind only if another bit was also set.
  function automatic logic more_than_one(input logic [DP_N_SRC-1:0] v);
    return (v & (v - {{(DP_N_SRC-1){1'b0}}, 1'b1})) != '0;
  endfunction

endpackage : bus_datapath_pkg
`default_nettype wire

// File: rtl/bus_datapath_if.sv
`default_nettype none
// ============================================================================
// Module   : bus_datapath_if
// Purpose  : Strobe and data bundle between the control unit (master) and
//            the register/bus datapath (slave).
// Ports    : e*/i* strobes, ipc/epc, instruction/RAM/ALU data in;
//            pc, cmd, reg0, alu_b, RAM address/data/write-enable, bus and
//            bus_err out of the datapath.
// Revision : 1.0 - initial release
// ============================================================================
interface bus_datapath_if #(
  parameter int WIDTH = 16,
  parameter int PC_W  = 8
);
  logic             idr_0, edr_0, idr_1, edr_1;
  logic             idr_bp, edr_bp, idr_sp, edr_sp;
  logic             iir, eir, imar, emar, iaddr;
  logic             iram, eram, ialu, ealu, ipc, epc;
  logic [WIDTH-1:0] instr_data, ram_rdata, alu_result;

  logic [PC_W-1:0]  pc;
  logic [WIDTH-1:0] cmd, reg0, alu_b, ram_addr, ram_wdata, bus;
  logic             ram_we, bus_err;

  modport master (
    output idr_0, edr_0, idr_1, edr_1, idr_bp, edr_bp, idr_sp, edr_sp,
           iir, eir, imar, emar, iaddr, iram, eram, ialu, ealu, ipc, epc,
           instr_data, ram_rdata, alu_result,
    input  pc, cmd, reg0, alu_b, ram_addr, ram_wdata, ram_we, bus, bus_err
  );

  modport slave (
    input  idr_0, edr_0, idr_1, edr_1, idr_bp, edr_bp, idr_sp, edr_sp,
           iir, eir, imar, emar, iaddr, iram, eram, ialu, ealu, ipc, epc,
           instr_data, ram_rdata, alu_result,
    output pc, cmd, reg0, alu_b, ram_addr, ram_wdata, ram_we, bus, bus_err
  );
endinterface : bus_datapath_if
`default_nettype wire

// File: rtl/bus_datapath_mux.sv
`default_nettype none
// ============================================================================
// Module   : bus_datapath_mux
// Purpose  : Priority selector for the shared internal bus plus contention
//            flag. Source 0 has the highest priority.
// Ports    : drv_en    in  8 source enables
//            drv_data  in  8 x WIDTH source words
//            bus       out WIDTH selected word (0 when nothing drives)
//            multi_drv out more than one enable active this cycle
// Revision : 1.0 - initial release
// ============================================================================
module bus_datapath_mux
  import bus_datapath_pkg::*;
#(
  parameter int WIDTH = DP_WIDTH
) (
  input  logic [DP_N_SRC-1:0]            drv_en,
  input  logic [DP_N_SRC-1:0][WIDTH-1:0] drv_data,
  output logic [WIDTH-1:0]               bus,
  output logic                           multi_drv
);

  // Walk from lowest to highest priority so the highest-priority enabled
  // source is the last assignment and wins.
  always_comb begin
    bus = '0;
    for (int i = DP_N_SRC - 1; i >= 0; i--) begin
      if (drv_en[i]) bus = drv_data[i];
    end
  end

  assign multi_drv = more_than_one(drv_en);

endmodule : bus_datapath_mux
`default_nettype wire

// File: rtl/bus_datapath.sv
`default_nettype none
// ============================================================================
// Module   : bus_datapath
// Purpose  : Register file and shared-bus responder for the SimpleCPU control
//            unit. e* strobes pick the bus source, i* strobes load targets
//            from the bus, IR loads from instruction memory, PC increments on
//            an ipc rising edge or loads from the bus on epc.
// Ports    : clk   in  rising-edge clock
//            reset in  asynchronous, active-low
//            bif   slave side of bus_datapath_if (strobes, data, results)
// Revision : 1.0 - initial release
// ============================================================================
module bus_datapath
  import bus_datapath_pkg::*;
#(
  parameter int               WIDTH    = DP_WIDTH,
  parameter int               PC_W     = DP_PC_W,
  parameter int               OPND_W   = DP_OPND_W,
  parameter logic [WIDTH-1:0] SP_RESET = DP_SP_RESET
) (
  input  logic           clk,
  input  logic           reset,
  bus_datapath_if.slave  bif
);

  logic [WIDTH-1:0] dr0_q, dr0_d, dr1_q, dr1_d, bp_q, bp_d, sp_q, sp_d;
  logic [WIDTH-1:0] mar_q, mar_d, addr_q, addr_d, ir_q, ir_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             ipc_q, ipc_d;
  logic             bus_err_q, bus_err_d;

  logic [WIDTH-1:0]               bus;
  logic                           multi_drv;
  logic [WIDTH-1:0]               eir_word;
  logic [DP_N_SRC-1:0]            drv_en;
  logic [DP_N_SRC-1:0][WIDTH-1:0] drv_data;

  assign eir_word = {{(WIDTH-OPND_W){1'b0}}, ir_q[OPND_W-1:0]};

  // Element 0 is the highest-priority source.
  assign drv_en   = {bif.ealu, bif.eram, bif.eir, bif.emar,
                     bif.edr_sp, bif.edr_bp, bif.edr_1, bif.edr_0};
  assign drv_data = {bif.alu_result, bif.ram_rdata, eir_word, mar_q,
                     sp_q, bp_q, dr1_q, dr0_q};

  bus_datapath_mux #(.WIDTH(WIDTH)) u_mux (
    .drv_en    (drv_en),
    .drv_data  (drv_data),
    .bus       (bus),
    .multi_drv (multi_drv)
  );

  always_comb begin
    dr0_d     = dr0_q;
    dr1_d     = dr1_q;
    bp_d      = bp_q;
    sp_d      = sp_q;
    mar_d     = mar_q;
    addr_d    = addr_q;
    ir_d      = ir_q;
    pc_d      = pc_q;
    ipc_d     = bif.ipc;
    bus_err_d = bus_err_q | multi_drv;

    // A register driving the bus while told to load keeps its value, even if
    // a higher-priority source has taken the bus.
    if (bif.idr_0  && !bif.edr_0)  dr0_d = bus;
    if (bif.idr_1  && !bif.edr_1)  dr1_d = bus;
    if (bif.idr_bp && !bif.edr_bp) bp_d  = bus;
    if (bif.idr_sp && !bif.edr_sp) sp_d  = bus;
    if (bif.imar   && !bif.emar)   mar_d = bus;
    if (bif.iaddr)                 addr_d = bus;
    if (bif.iir)                   ir_d  = bif.instr_data;

    // Load beats a simultaneous increment edge; the edge is still consumed
    // because ipc_q follows ipc regardless.
    if (bif.epc)                   pc_d = bus[PC_W-1:0];
    else if (bif.ipc && !ipc_q)    pc_d = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dr0_q     <= '0;
      dr1_q     <= '0;
      bp_q      <= '0;
      sp_q      <= SP_RESET;
      mar_q     <= '0;
      addr_q    <= '0;
      ir_q      <= '0;
      pc_q      <= '0;
      ipc_q     <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      dr0_q     <= dr0_d;
      dr1_q     <= dr1_d;
      bp_q      <= bp_d;
      sp_q      <= sp_d;
      mar_q     <= mar_d;
      addr_q    <= addr_d;
      ir_q      <= ir_d;
      pc_q      <= pc_d;
      ipc_q     <= ipc_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign bif.pc        = pc_q;
  assign bif.cmd       = ir_q;
  assign bif.reg0      = dr0_q;
  assign bif.alu_b     = bif.ialu ? bus : '0;
  assign bif.ram_addr  = addr_q;
  assign bif.ram_wdata = bus;
  assign bif.ram_we    = bif.iram;
  assign bif.bus       = bus;
  assign bif.bus_err   = bus_err_q;

endmodule : bus_datapath
`default_nettype wire

// File: tb/tb_bus_datapath.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_datapath
// Purpose  : Directed self-checking bench for bus_datapath.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_datapath;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  bus_datapath_if #(.WIDTH(16), .PC_W(8)) bif ();

  bus_datapath #(
    .WIDTH(16), .PC_W(8), .OPND_W(8), .SP_RESET(16'h00FF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bif   (bif)
  );

  task automatic clear_strobes();
    bif.idr_0 = 0; bif.edr_0 = 0; bif.idr_1 = 0; bif.edr_1 = 0;
    bif.idr_bp = 0; bif.edr_bp = 0; bif.idr_sp = 0; bif.edr_sp = 0;
    bif.iir = 0; bif.eir = 0; bif.imar = 0; bif.emar = 0; bif.iaddr = 0;
    bif.iram = 0; bif.eram = 0; bif.ialu = 0; bif.ealu = 0;
    bif.ipc = 0; bif.epc = 0;
  endtask

  // Advance one clock; inputs set after this return are sampled on the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_strobes();
    bif.instr_data = 16'h0; bif.ram_rdata = 16'h0; bif.alu_result = 16'h0;
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    #1;
    total_cnt++; if (bif.pc !== 8'h00) $display("FAIL reset_pc: got %h want 00", bif.pc); else pass_cnt++;
    total_cnt++; if (bif.cmd !== 16'h0) $display("FAIL reset_cmd: got %h want 0000", bif.cmd); else pass_cnt++;
    total_cnt++; if (bif.reg0 !== 16'h0) $display("FAIL reset_reg0: got %h want 0000", bif.reg0); else pass_cnt++;
    total_cnt++; if (bif.bus_err !== 1'b0) $display("FAIL reset_bus_err: got %b want 0", bif.bus_err); else pass_cnt++;
    bif.edr_sp = 1; #1;
    total_cnt++; if (bif.bus !== 16'h00FF) $display("FAIL reset_sp: got %h want 00ff", bif.bus); else pass_cnt++;
    total_cnt++; if (bif.bus !== 16'h00FF) $display("FAIL reset_sp_bus_idle: no-bus check got %h want 00ff", bif.bus); else pass_cnt++;
    bif.edr_sp = 0;
    bif.iir = 1; bif.instr_data = 16'h1234;
    tick();
    bif.iir = 0; bif.instr_data = 16'hFFFF;
    #1;
    total_cnt++; if (bif.cmd !== 16'h1234) $display("FAIL fetch_cmd: got %h want 1234", bif.cmd); else pass_cnt++;
    total_cnt++; if (bif.bus !== 16'h0000) $display("FAIL idle_bus: got %h want 0000", bif.bus); else pass_cnt++;
  endtask

  task automatic test_eir_copy();
    bif.iir = 1; bif.instr_data = 16'hAB5C;
    tick();
    clear_strobes();
    bif.eir = 1; bif.idr_1 = 1; #1;
    total_cnt++; if (bif.bus !== 16'h005C) $display("FAIL eir_bus: got %h want 005c", bif.bus); else pass_cnt++;
    tick();
    clear_strobes();
    bif.edr_1 = 1; bif.idr_bp = 1; #1;
    total_cnt++; if (bif.bus !== 16'h005C) $display("FAIL dr1_value: got %h want 005c", bif.bus); else pass_cnt++;
    tick();
    clear_strobes();
    bif.edr_bp = 1; #1;
    total_cnt++; if (bif.bus !== 16'h005C) $display("FAIL bp_value: got %h want 005c", bif.bus); else pass_cnt++;
    clear_strobes();
  endtask

  task automatic test_pc();
    bif.ipc = 1;
    tick();
    total_cnt++; if (bif.pc !== 8'h01) $display("FAIL pc_inc_first: got %h want 01", bif.pc); else pass_cnt++;
    repeat (2) tick();
    total_cnt++; if (bif.pc !== 8'h01) $display("FAIL pc_inc_held: got %h want 01", bif.pc); else pass_cnt++;
    bif.ipc = 0;
    bif.ealu = 1; bif.alu_result = 16'h12FF; bif.epc = 1;
    tick();
    clear_strobes();
    total_cnt++; if (bif.pc !== 8'hFF) $display("FAIL pc_load_ff: got %h want ff", bif.pc); else pass_cnt++;
    bif.ipc = 1;
    tick();
    bif.ipc = 0;
    total_cnt++; if (bif.pc !== 8'h00) $display("FAIL pc_wrap: got %h want 00", bif.pc); else pass_cnt++;
    tick();
  endtask

  task automatic test_epc_priority();
    bif.ealu = 1; bif.alu_result = 16'h0142; bif.imar = 1;
    tick();
    clear_strobes();
    bif.emar = 1; bif.epc = 1; bif.ipc = 1; #1;
    total_cnt++; if (bif.bus !== 16'h0142) $display("FAIL mar_bus: got %h want 0142", bif.bus); else pass_cnt++;
    tick();
    bif.emar = 0; bif.epc = 0;
    total_cnt++; if (bif.pc !== 8'h42) $display("FAIL epc_wins: got %h want 42", bif.pc); else pass_cnt++;
    tick();
    total_cnt++; if (bif.pc !== 8'h42) $display("FAIL epc_edge_consumed: got %h want 42", bif.pc); else pass_cnt++;
    clear_strobes();
    tick();
  endtask

  task automatic test_alu_and_multi_load();
    bif.ealu = 1; bif.alu_result = 16'h5A5A; bif.ialu = 1; #1;
    total_cnt++; if (bif.alu_b !== 16'h5A5A) $display("FAIL alu_b_on: got %h want 5a5a", bif.alu_b); else pass_cnt++;
    bif.ialu = 0; #1;
    total_cnt++; if (bif.alu_b !== 16'h0000) $display("FAIL alu_b_off: got %h want 0000", bif.alu_b); else pass_cnt++;
    bif.alu_result = 16'h0BEE; bif.idr_0 = 1; bif.idr_1 = 1;
    tick();
    clear_strobes();
    total_cnt++; if (bif.reg0 !== 16'h0BEE) $display("FAIL multi_load_dr0: got %h want 0bee", bif.reg0); else pass_cnt++;
    bif.edr_1 = 1; #1;
    total_cnt++; if (bif.bus !== 16'h0BEE) $display("FAIL multi_load_dr1: got %h want 0bee", bif.bus); else pass_cnt++;
    clear_strobes();
  endtask

  task automatic test_ram();
    bif.ealu = 1; bif.alu_result = 16'h0010; bif.idr_0 = 1;
    tick();
    bif.alu_result = 16'h0077; bif.idr_0 = 0; bif.idr_1 = 1;
    tick();
    clear_strobes();
    total_cnt++; if (bif.reg0 !== 16'h0010) $display("FAIL ram_dr0: got %h want 0010", bif.reg0); else pass_cnt++;
    bif.edr_0 = 1; bif.iaddr = 1;
    tick();
    clear_strobes();
    total_cnt++; if (bif.ram_addr !== 16'h0010) $display("FAIL ram_addr: got %h want 0010", bif.ram_addr); else pass_cnt++;
    bif.edr_1 = 1; bif.iram = 1; #1;
    total_cnt++; if (bif.ram_wdata !== 16'h0077) $display("FAIL ram_wdata: got %h want 0077", bif.ram_wdata); else pass_cnt++;
    total_cnt++; if (bif.ram_we !== 1'b1) $display("FAIL ram_we_on: got %b want 1", bif.ram_we); else pass_cnt++;
    tick();
    clear_strobes(); #1;
    total_cnt++; if (bif.ram_we !== 1'b0) $display("FAIL ram_we_off: got %b want 0", bif.ram_we); else pass_cnt++;
    bif.eram = 1; bif.iram = 1; bif.ram_rdata = 16'h3333; #1;
    total_cnt++; if (bif.ram_wdata !== 16'h3333) $display("FAIL ram_rmw_data: got %h want 3333", bif.ram_wdata); else pass_cnt++;
    tick();
    clear_strobes();
    total_cnt++; if (bif.bus_err !== 1'b0) $display("FAIL ram_rmw_err: got %b want 0", bif.bus_err); else pass_cnt++;
  endtask

  task automatic test_multi_driver();
    bif.edr_0 = 1; bif.edr_sp = 1; #1;
    total_cnt++; if (bif.bus !== 16'h0010) $display("FAIL contention_bus: got %h want 0010", bif.bus); else pass_cnt++;
    tick();
    clear_strobes();
    total_cnt++; if (bif.bus_err !== 1'b1) $display("FAIL bus_err_set: got %b want 1", bif.bus_err); else pass_cnt++;
    repeat (3) tick();
    total_cnt++; if (bif.bus_err !== 1'b1) $display("FAIL bus_err_sticky: got %b want 1", bif.bus_err); else pass_cnt++;
  endtask

  task automatic test_async_reset_ipc();
    // Assert reset between clock edges; state must clear without a clock.
    #1;
    reset = 1'b0; bif.ipc = 1;
    #1;
    total_cnt++; if (bif.bus_err !== 1'b0) $display("FAIL async_bus_err: got %b want 0", bif.bus_err); else pass_cnt++;
    total_cnt++; if (bif.pc !== 8'h00) $display("FAIL async_pc: got %h want 00", bif.pc); else pass_cnt++;
    total_cnt++; if (bif.reg0 !== 16'h0000) $display("FAIL async_reg0: got %h want 0000", bif.reg0); else pass_cnt++;
    tick();
    reset = 1'b1;
    tick();
    total_cnt++; if (bif.pc !== 8'h01) $display("FAIL post_reset_edge: got %h want 01", bif.pc); else pass_cnt++;
    tick();
    total_cnt++; if (bif.pc !== 8'h01) $display("FAIL post_reset_once: got %h want 01", bif.pc); else pass_cnt++;
    clear_strobes();
  endtask

  initial begin
    test_reset();
    test_eir_copy();
    test_pc();
    test_epc_priority();
    test_alu_and_multi_load();
    test_ram();
    test_multi_driver();
    test_async_reset_ipc();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_bus_datapath
`default_nettype wire
